vga_disp_core: RTL and testbench



---
 rtl/vga_disp_core.sv | 139 +++++++++++++
 tb/tb_vga_disp_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_disp_core.sv
// VGA display core: pixel-tick divider, H/V timing generator and latency-aligned sync/RGB outputs.
// Defining VGA_TEST_PATTERN_EN adds a test_en input selecting an eight-bar colour pattern.
module vga_disp_core #(
  parameter int DIV       = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int RGB_W     = 3,
  parameter int GEN_LAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  input  logic [RGB_W-1:0] rgb_in,
  output logic             p_tick,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       SP       = 1'(SYNC_POL);

`ifdef VGA_TEST_PATTERN_EN
  localparam int         PW    = 6;
  localparam int         FW    = RGB_W / 3;
  localparam logic [9:0] BAR_W = 10'(H_DISPLAY / 8);
`else
  localparam int         PW    = 3;
`endif
  localparam logic [PW-1:0] IDLE = PW'({~SP, ~SP, 1'b0});

  logic [DW-1:0]    div_cnt;
  logic [9:0]       h, v;
  logic [PW-1:0]    raw_vec, stage;
  logic [RGB_W-1:0] colour;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      p_tick  <= (div_cnt == DIV_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign pixel_x     = h;
  assign pixel_y     = v;
  assign frame_start = p_tick & (h == H_LAST) & (v == V_LAST);

  // Packed as {bar, hs, vs, von}; the bar field only exists with the test pattern.
  always_comb begin
    raw_vec    = IDLE;
    raw_vec[2] = (h >= HS_START && h <= HS_END) ? SP : ~SP;
    raw_vec[1] = (v >= VS_START && v <= VS_END) ? SP : ~SP;
    raw_vec[0] = (h < H_VIS) && (v < V_VIS);
`ifdef VGA_TEST_PATTERN_EN
    raw_vec[5:3] = 3'(h / BAR_W);
`endif
  end

  generate
    if (GEN_LAT == 0) begin : g_nolat
      assign stage = raw_vec;
    end else begin : g_lat
      logic [PW-1:0] pipe [GEN_LAT];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < GEN_LAT; i++) pipe[i] <= IDLE;
        end else if (p_tick) begin
          pipe[0] <= raw_vec;
          for (int unsigned i = 1; i < GEN_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign stage = pipe[GEN_LAT-1];
    end
  endgenerate

  always_comb begin
    colour = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
    if (test_en) colour = {{FW{stage[5]}}, {FW{stage[4]}}, {FW{stage[3]}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync    <= ~SP;
      vsync    <= ~SP;
      video_on <= 1'b0;
      rgb      <= '0;
    end else if (p_tick) begin
      hsync    <= stage[2];
      vsync    <= stage[1];
      video_on <= stage[0];
      rgb      <= stage[0] ? colour : '0;
    end
  end

endmodule

// File: tb/tb_vga_disp_core.sv
// Self-checking bench for vga_disp_core: two configurations checked every cycle against
// a closed-form timing model driven by randomized generator colours and a mid-run reset.
module tb_vga_disp_core;

  localparam int NCYC = 4000;

  typedef struct { int div, hd, hf, hs, hb, vd, vf, vs, vb, pol, lat, w; } cfg_t;
  typedef struct { int p, x, y, fs, hs, vs, von, rgb; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] rgb_in_a, rgb_a;
  logic [2:0] rgb_in_b, rgb_b;
  logic       p_tick_a, frame_start_a, hsync_a, vsync_a, video_on_a;
  logic       p_tick_b, frame_start_b, hsync_b, vsync_b, video_on_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_en_a, test_en_b;
`endif

  vga_disp_core #(
    .DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(4), .H_BACK(4),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(0), .RGB_W(6), .GEN_LAT(2)
  ) dut_a (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en_a),
`endif
    .rgb_in(rgb_in_a), .p_tick(p_tick_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .frame_start(frame_start_a), .hsync(hsync_a), .vsync(vsync_a),
    .video_on(video_on_a), .rgb(rgb_a)
  );

  vga_disp_core #(
    .DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1), .RGB_W(3), .GEN_LAT(0)
  ) dut_b (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en_b),
`endif
    .rgb_in(rgb_in_b), .p_tick(p_tick_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .frame_start(frame_start_b), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .rgb(rgb_b)
  );

  int col [2][400];
  int n_checks, n_fail;
  int k;
  int te_last [2];
  int te_now [2];

  function automatic cfg_t get_cfg(input int c);
    cfg_t r;
    if (c == 0) r = '{2, 16, 4, 4, 4, 6, 2, 2, 2, 0, 2, 6};
    else        r = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 3};
    return r;
  endfunction

  function automatic int bar_col(input cfg_t c, input int h);
    int bar, fw, ones;
    bar  = (h / (c.hd / 8)) % 8;
    fw   = c.w / 3;
    ones = (1 << fw) - 1;
    return ((((bar >> 2) & 1) * ones) << (2 * fw)) | ((((bar >> 1) & 1) * ones) << fw) | ((bar & 1) * ones);
  endfunction

  // Expected outputs after kk clock edges since reset: n completed pixel ticks,
  // outputs reflect the raw terms of the position GEN_LAT+1 ticks back.
  function automatic exp_t model(input int ci, input int kk, input int te);
    cfg_t c;
    exp_t e;
    int ht, vt, tot, n, pos, t, th, tv;
    c   = get_cfg(ci);
    ht  = c.hd + c.hf + c.hs + c.hb;
    vt  = c.vd + c.vf + c.vs + c.vb;
    tot = ht * vt;
    n   = (kk >= 1) ? (kk - 1) / c.div : 0;
    pos = n % tot;
    e.p  = (kk >= 1 && kk % c.div == 0) ? 1 : 0;
    e.x  = pos % ht;
    e.y  = pos / ht;
    e.fs = (e.p == 1 && pos == tot - 1) ? 1 : 0;
    t = n - 1 - c.lat;
    if (t < 0) begin
      e.hs = 1 - c.pol; e.vs = 1 - c.pol; e.von = 0; e.rgb = 0;
    end else begin
      t  = t % tot;
      th = t % ht;
      tv = t / ht;
      e.hs  = (th >= c.hd + c.hf && th < c.hd + c.hf + c.hs) ? c.pol : 1 - c.pol;
      e.vs  = (tv >= c.vd + c.vf && tv < c.vd + c.vf + c.vs) ? c.pol : 1 - c.pol;
      e.von = (th < c.hd && tv < c.vd) ? 1 : 0;
      e.rgb = (e.von == 0) ? 0 : ((te != 0) ? bar_col(c, th) : col[ci][t]);
    end
    return e;
  endfunction

  // Generator behaviour: on a tick, return the colour of the address issued GEN_LAT ticks ago.
  function automatic int gen_drive(input int ci, input int kk);
    cfg_t c;
    int tot, n, mask;
    c    = get_cfg(ci);
    tot  = (c.hd + c.hf + c.hs + c.hb) * (c.vd + c.vf + c.vs + c.vb);
    n    = (kk >= 1) ? (kk - 1) / c.div : 0;
    mask = (1 << c.w) - 1;
    if (kk >= 1 && kk % c.div == 0 && n - c.lat >= 0) return col[ci][(n - c.lat) % tot];
    return int'($urandom) & mask;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input int p, input int x, input int y,
                           input int fs, input int hs, input int vs, input int von, input int rgb);
    check({tag, ".p_tick"}, p, e.p);
    check({tag, ".pixel_x"}, x, e.x);
    check({tag, ".pixel_y"}, y, e.y);
    check({tag, ".frame_start"}, fs, e.fs);
    check({tag, ".hsync"}, hs, e.hs);
    check({tag, ".vsync"}, vs, e.vs);
    check({tag, ".video_on"}, von, e.von);
    check({tag, ".rgb"}, rgb, e.rgb);
  endtask

  initial begin
    cfg_t c;
    exp_t ea, eb;
    int started, rst_at, fs_prev, wrap_prev, prev_x, hs_cnt, ht, mask;

    reset    = 1'b1;
    rgb_in_a = '0;
    rgb_in_b = '0;
`ifdef VGA_TEST_PATTERN_EN
    test_en_a = 1'b0;
    test_en_b = 1'b0;
`endif
    n_checks = 0; n_fail = 0; k = 0;
    te_last = '{0, 0};
    te_now  = '{0, 0};
    started = 0; fs_prev = -1; wrap_prev = -1; prev_x = 0; hs_cnt = 0;

    // Blanking positions carry all-ones so any leak past the blanking gate is visible.
    for (int ci = 0; ci < 2; ci++) begin
      c    = get_cfg(ci);
      ht   = c.hd + c.hf + c.hs + c.hb;
      mask = (1 << c.w) - 1;
      for (int p = 0; p < 400; p++)
        col[ci][p] = ((p % ht) < c.hd && (p / ht) < c.vd) ? (int'($urandom) & mask) : mask;
    end
    rst_at = int'($urandom_range(1500, 2500));

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (reset) begin
        k = 0;
        started = 1;
        fs_prev = -1;
        wrap_prev = -1;
        prev_x = 0;
      end else begin
        for (int ci = 0; ci < 2; ci++)
          if (model(ci, k, 0).p == 1) te_last[ci] = te_now[ci];
        k++;
      end
      #1;
      if (started != 0) begin
        ea = model(0, k, te_last[0]);
        eb = model(1, k, te_last[1]);
        check_dut("a", ea, int'(p_tick_a), int'(pixel_x_a), int'(pixel_y_a), int'(frame_start_a),
                  int'(hsync_a), int'(vsync_a), int'(video_on_a), int'(rgb_a));
        check_dut("b", eb, int'(p_tick_b), int'(pixel_x_b), int'(pixel_y_b), int'(frame_start_b),
                  int'(hsync_b), int'(vsync_b), int'(video_on_b), int'(rgb_b));

        if (k == 1) check("a.first_tick_k1", int'(p_tick_a), 0);
        if (k == 2) check("a.first_tick_k2", int'(p_tick_a), 1);

        if (reset == 1'b0 && k > 0) begin
          if (frame_start_b) begin
            if (fs_prev >= 0) check("b.frame_period_clk", cyc - fs_prev, 98);
            fs_prev = cyc;
          end
          if (int'(pixel_x_b) == 0 && prev_x != 0) begin
            if (wrap_prev >= 0) begin
              check("b.line_period_clk", cyc - wrap_prev, 14);
              check("b.hsync_high_per_line", hs_cnt, 2);
            end
            wrap_prev = cyc;
            hs_cnt = 0;
          end
          if (hsync_b) hs_cnt++;
          prev_x = int'(pixel_x_b);
        end
      end

      reset    = (cyc < 3) || (cyc >= rst_at && cyc < rst_at + 3);
      rgb_in_a = 6'(gen_drive(0, k));
      rgb_in_b = 3'(gen_drive(1, k));
`ifdef VGA_TEST_PATTERN_EN
      if ($urandom_range(0, 19) == 0) test_en_b = ~test_en_b;
      te_now[1] = int'(test_en_b);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
